// File: rtl/eeprom_pkg.sv
// Shared types and defaults for the EEPROM verify sequencer and its request helper.
package eeprom_pkg;

  localparam int unsigned EEPROM_ADDR_W      = 13;        // 24LC64: 8 KB
  localparam int unsigned DEF_TWC_CYCLES     = 250000;    // 5 ms at 50 MHz
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;
  localparam logic [7:0]  DEF_SEED           = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    WR_TWC,
    RD_REQ,
    RD_WAIT,
    CMP,
    FINISH
  } seq_state_t;

  // Test pattern: descending bytes starting at the seed.
  function automatic logic [7:0] pattern_byte(input logic [7:0] seed, input logic [15:0] idx);
    return seed - idx[7:0];
  endfunction

endpackage

// File: rtl/eeprom_req_pulse.sv
// Edge detection on the eeprom_rw bit clock and done flag, plus the
// one-bit-clock-period enable pulse shared by the write and read paths.
module eeprom_req_pulse
  import eeprom_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic Eeprom_clk,
  input  logic Eeprom_done,
  input  logic i_start,
  input  logic i_rd,
  input  logic i_abort,
  output logic o_wr_en,
  output logic o_rd_en,
  output logic o_en_rise_c,
  output logic o_done_rise_c
);

  logic r_clk_cur;
  logic r_clk_prev;
  logic r_done_cur;
  logic r_done_prev;
  logic r_armed;
  logic r_rd;
  logic r_wr_en;
  logic r_rd_en;
  logic w_clk_rise;

  assign w_clk_rise    = r_clk_cur & ~r_clk_prev;
  assign o_done_rise_c = r_done_cur & ~r_done_prev;
  assign o_en_rise_c   = r_armed & w_clk_rise & ~i_start & ~i_abort;
  assign o_wr_en       = r_wr_en;
  assign o_rd_en       = r_rd_en;

  // Armed on request; enable rises at the next bit-clock edge and falls at the one after.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_clk_cur   <= 1'b0;
      r_clk_prev  <= 1'b0;
      r_done_cur  <= 1'b0;
      r_done_prev <= 1'b0;
      r_armed     <= 1'b0;
      r_rd        <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
    end else begin
      r_clk_cur   <= Eeprom_clk;
      r_clk_prev  <= r_clk_cur;
      r_done_cur  <= Eeprom_done;
      r_done_prev <= r_done_cur;
      if (i_abort) begin
        r_armed <= 1'b0;
        r_wr_en <= 1'b0;
        r_rd_en <= 1'b0;
      end else if (i_start) begin
        r_armed <= 1'b1;
        r_rd    <= i_rd;
      end else if (w_clk_rise) begin
        if (r_armed) begin
          r_armed <= 1'b0;
          r_wr_en <= ~r_rd;
          r_rd_en <= r_rd;
        end else begin
          r_wr_en <= 1'b0;
          r_rd_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/eeprom_verify_seq.sv
// Write-then-readback self-test sequencer placed in front of eeprom_rw;
// reports pass/fail, mismatch count and first failing address.
module eeprom_verify_seq
  import eeprom_pkg::*;
#(
  parameter int unsigned ADDR_W         = EEPROM_ADDR_W,
  parameter logic [7:0]  SEED           = DEF_SEED,
  parameter int unsigned TWC_CYCLES     = DEF_TWC_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [15:0] Base_addr,
  input  logic [15:0] Length,
  input  logic        Eeprom_clk,
  input  logic        Eeprom_done,
  input  logic [7:0]  Eeprom_rd_data,
  output logic        Eeprom_wr_en,
  output logic        Eeprom_rd_en,
  output logic [15:0] Eeprom_addr,
  output logic [7:0]  Eeprom_wr_data,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [15:0] Err_cnt,
  output logic [15:0] First_err_addr,
  output logic        Timeout
);

  localparam logic [15:0] ADDR_MASK = 16'((33'd1 << ADDR_W) - 33'd1);
  localparam int unsigned TWC_W     = (TWC_CYCLES > 1) ? $clog2(TWC_CYCLES) : 1;
  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic [15:0]      r_base;
  logic [15:0]      r_len;
  logic [15:0]      r_idx;
  logic [TWC_W-1:0] r_twc_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_to_run;
  logic [7:0]       r_rd_byte;
  logic [15:0]      r_addr;
  logic [7:0]       r_wr_data;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_err_cnt;
  logic [15:0]      r_first_err;
  logic             r_timeout;

  logic        w_done_rise;
  logic        w_en_rise;
  logic        w_more;
  logic        w_twc_last;
  logic        w_to_hit;
  logic [15:0] w_addr_cur;
  logic [7:0]  w_pat_cur;

  logic w_accept;
  logic w_req_start;
  logic w_req_rd;
  logic w_abort;
  logic w_twc_start;
  logic w_idx_inc;
  logic w_idx_clr;
  logic w_capture;
  logic w_cmp;
  logic w_timeout;

  assign w_addr_cur = (r_base + r_idx) & ADDR_MASK;
  assign w_pat_cur  = pattern_byte(SEED, r_idx);
  assign w_more     = (17'(r_idx) + 17'd1) < 17'(r_len);
  assign w_twc_last = (r_twc_cnt == TWC_W'(TWC_CYCLES - 1));
  assign w_to_hit   = r_to_run && (r_to_cnt == TO_W'(TIMEOUT_CYCLES));

  eeprom_req_pulse u_req_pulse (
    .Clk           (Clk),
    .Rst           (Rst),
    .Eeprom_clk    (Eeprom_clk),
    .Eeprom_done   (Eeprom_done),
    .i_start       (w_req_start),
    .i_rd          (w_req_rd),
    .i_abort       (w_abort),
    .o_wr_en       (Eeprom_wr_en),
    .o_rd_en       (Eeprom_rd_en),
    .o_en_rise_c   (w_en_rise),
    .o_done_rise_c (w_done_rise)
  );

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_req_start = 1'b0;
    w_req_rd    = 1'b0;
    w_abort     = 1'b0;
    w_twc_start = 1'b0;
    w_idx_inc   = 1'b0;
    w_idx_clr   = 1'b0;
    w_capture   = 1'b0;
    w_cmp       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_accept    = 1'b1;
          w_state_nxt = (Length == 16'd0) ? FINISH : WR_REQ;
        end
      end
      WR_REQ: begin
        w_req_start = 1'b1;
        w_state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (w_done_rise) begin
          w_twc_start = 1'b1;
          w_state_nxt = WR_TWC;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      WR_TWC: begin
        if (w_twc_last) begin
          if (w_more) begin
            w_idx_inc   = 1'b1;
            w_state_nxt = WR_REQ;
          end else begin
            w_idx_clr   = 1'b1;
            w_state_nxt = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        w_req_start = 1'b1;
        w_req_rd    = 1'b1;
        w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (w_done_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = CMP;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_abort     = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      CMP: begin
        w_cmp = 1'b1;
        if (w_more) begin
          w_idx_inc   = 1'b1;
          w_state_nxt = RD_REQ;
        end else begin
          w_state_nxt = FINISH;
        end
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: run parameters, address/data, counters and result registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_base      <= 16'd0;
      r_len       <= 16'd0;
      r_idx       <= 16'd0;
      r_twc_cnt   <= '0;
      r_to_cnt    <= '0;
      r_to_run    <= 1'b0;
      r_rd_byte   <= 8'd0;
      r_addr      <= 16'd0;
      r_wr_data   <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= 16'd0;
      r_first_err <= 16'hFFFF;
      r_timeout   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_accept) begin
        r_base      <= Base_addr;
        r_len       <= Length;
        r_idx       <= 16'd0;
        r_err_cnt   <= 16'd0;
        r_first_err <= 16'hFFFF;
        r_timeout   <= 1'b0;
        r_pass      <= 1'b0;
        r_busy      <= 1'b1;
      end

      // Timeout window opens when the enable actually asserts.
      if (w_req_start) begin
        r_addr   <= w_addr_cur;
        r_to_run <= 1'b0;
        r_to_cnt <= '0;
        if (!w_req_rd) r_wr_data <= w_pat_cur;
      end else if (w_en_rise) begin
        r_to_run <= 1'b1;
        r_to_cnt <= '0;
      end else if (r_to_run && !w_to_hit) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (w_twc_start)            r_twc_cnt <= '0;
      else if (r_state == WR_TWC) r_twc_cnt <= r_twc_cnt + TWC_W'(1);

      if (w_capture) r_rd_byte <= Eeprom_rd_data;

      if (w_cmp && (r_rd_byte != w_pat_cur)) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0)    r_first_err <= r_addr;
      end

      if (w_idx_inc)      r_idx <= r_idx + 16'd1;
      else if (w_idx_clr) r_idx <= 16'd0;

      if (w_timeout) r_timeout <= 1'b1;

      if (r_state == FINISH) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
        r_pass <= (r_err_cnt == 16'd0) && !r_timeout;
      end
    end
  end

  assign Eeprom_addr    = r_addr;
  assign Eeprom_wr_data = r_wr_data;
  assign Busy           = r_busy;
  assign Done           = r_done;
  assign Pass           = r_pass;
  assign Err_cnt        = r_err_cnt;
  assign First_err_addr = r_first_err;
  assign Timeout        = r_timeout;

endmodule

// File: tb/tb_eeprom_verify_seq.sv
// Self-checking bench: behavioural eeprom_rw/EEPROM stand-in plus a
// pattern/memory reference model predicting transactions and results.
module tb_eeprom_verify_seq;

  localparam int unsigned TB_TWC  = 50;
  localparam int unsigned TB_TO   = 2000;
  localparam logic [7:0]  TB_SEED = 8'hFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] length = 16'd0;
  logic        eclk = 1'b0;
  logic        edone = 1'b0;
  logic [7:0]  rd_data = 8'd0;
  logic        wr_en, rd_en;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic        busy, done, pass, tmo;
  logic [15:0] err_cnt, first_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5  clk  = ~clk;
  always #40 eclk = ~eclk;

  eeprom_verify_seq #(
    .ADDR_W(13), .SEED(TB_SEED), .TWC_CYCLES(TB_TWC), .TIMEOUT_CYCLES(TB_TO)
  ) dut (
    .Clk(clk), .Rst(rst), .Start(start), .Base_addr(base_addr), .Length(length),
    .Eeprom_clk(eclk), .Eeprom_done(edone), .Eeprom_rd_data(rd_data),
    .Eeprom_wr_en(wr_en), .Eeprom_rd_en(rd_en), .Eeprom_addr(addr),
    .Eeprom_wr_data(wr_data), .Busy(busy), .Done(done), .Pass(pass),
    .Err_cnt(err_cnt), .First_err_addr(first_err), .Timeout(tmo)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Device stand-in: EEPROM array, fixed response latency, optional read corruption.
  logic [7:0]  mem [8192];
  logic        corrupt_en = 1'b0;
  logic [15:0] corrupt_addr = 16'd0;
  logic        tie_low = 1'b0;
  logic        dev_busy = 1'b0, dev_rd = 1'b0, dev_wr_q = 1'b0, dev_rd_q = 1'b0;
  logic [12:0] dev_addr = 13'd0;
  int          dev_cnt = 0;

  always @(posedge clk) begin
    dev_wr_q <= wr_en;
    dev_rd_q <= rd_en;
    if (!dev_busy) begin
      if ((wr_en && !dev_wr_q) || (rd_en && !dev_rd_q)) begin
        dev_busy <= 1'b1;
        dev_cnt  <= 0;
        dev_rd   <= rd_en;
        dev_addr <= addr[12:0];
        if (wr_en) mem[addr[12:0]] <= wr_data;
      end
    end else begin
      dev_cnt <= dev_cnt + 1;
      if (dev_cnt == 18 && dev_rd)
        rd_data <= mem[dev_addr] ^ ((corrupt_en && dev_addr == corrupt_addr[12:0]) ? 8'h01 : 8'h00);
      if (dev_cnt == 19 && !tie_low) edone <= 1'b1;
      if (dev_cnt == 22) begin
        edone    <= 1'b0;
        dev_busy <= 1'b0;
      end
    end
  end

  // Transaction monitor against the predicted queue.
  typedef struct {
    bit          rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;
  txn_t exp_q[$];
  int   cyc = 0, en_start = 0, n_en = 0;
  logic mon_wr_q = 1'b0, mon_rd_q = 1'b0;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    mon_wr_q <= wr_en;
    mon_rd_q <= rd_en;
    if ((wr_en && !mon_wr_q) || (rd_en && !mon_rd_q)) begin
      en_start <= cyc;
      n_en     <= n_en + 1;
      check("en_exclusive", 32'(wr_en & rd_en), 32'd0);
      if (exp_q.size() == 0) begin
        check("txn_unexpected", 32'd1, 32'd0);
      end else begin
        check("txn_kind", 32'(rd_en), 32'(exp_q[0].rd));
        check("txn_addr", 32'(addr), 32'(exp_q[0].addr));
        if (!exp_q[0].rd) check("txn_wdata", 32'(wr_data), 32'(exp_q[0].data));
        void'(exp_q.pop_front());
      end
    end
    if ((!wr_en && mon_wr_q) || (!rd_en && mon_rd_q))
      check("en_width", 32'(cyc - en_start), 32'd8);
  end

  task automatic check_reset(input string tag);
    check({tag, "_wr_en"},  32'(wr_en),     32'd0);
    check({tag, "_rd_en"},  32'(rd_en),     32'd0);
    check({tag, "_addr"},   32'(addr),      32'd0);
    check({tag, "_wdata"},  32'(wr_data),   32'd0);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_done"},   32'(done),      32'd0);
    check({tag, "_pass"},   32'(pass),      32'd0);
    check({tag, "_err"},    32'(err_cnt),   32'd0);
    check({tag, "_first"},  32'(first_err), 32'h0000FFFF);
    check({tag, "_tmo"},    32'(tmo),       32'd0);
  endtask

  // Predict from the pattern rules: writes land in a sparse memory, reads compare against it.
  task automatic run_test(input string name, input logic [15:0] base, input int len,
                          input bit cor, input logic [15:0] cor_addr, input bit tie, input bit mid);
    logic [7:0]  ref_mem [int];
    int          exp_err;
    logic [15:0] exp_first;
    bit          exp_to;
    int          n;
    int          en_before;
    logic [15:0] a;
    logic [7:0]  pat, got;
    exp_err   = 0;
    exp_first = 16'hFFFF;
    exp_to    = tie && (len > 0);
    corrupt_en   = cor;
    corrupt_addr = cor_addr;
    tie_low      = tie;
    if (exp_to) begin
      exp_q.push_back('{rd: 1'b0, addr: base & 16'h1FFF, data: TB_SEED});
    end else begin
      for (int i = 0; i < len; i++) begin
        a   = (base + 16'(i)) & 16'h1FFF;
        pat = TB_SEED - 8'(i);
        ref_mem[int'(a)] = pat;
        exp_q.push_back('{rd: 1'b0, addr: a, data: pat});
      end
      for (int i = 0; i < len; i++) begin
        a   = (base + 16'(i)) & 16'h1FFF;
        pat = TB_SEED - 8'(i);
        got = ref_mem[int'(a)] ^ ((cor && a == cor_addr) ? 8'h01 : 8'h00);
        exp_q.push_back('{rd: 1'b1, addr: a, data: 8'h00});
        if (got != pat) begin
          if (exp_err == 0) exp_first = a;
          if (exp_err < 65535) exp_err++;
        end
      end
    end
    en_before = n_en;
    base_addr = base;
    length    = 16'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20000) begin
      tick();
      n++;
      start = mid && (n == 40);
    end
    start = 1'b0;
    check({name, "_done_seen"}, 32'(done), 32'd1);
    if (len == 0) begin
      check({name, "_latency_ok"}, 32'(n <= 2), 32'd1);
      check({name, "_no_enable"},  32'(n_en - en_before), 32'd0);
    end
    check({name, "_pass"},    32'(pass),      32'((exp_err == 0) && !exp_to));
    check({name, "_err_cnt"}, 32'(err_cnt),   32'(exp_err));
    check({name, "_first"},   32'(first_err), 32'(exp_first));
    check({name, "_timeout"}, 32'(tmo),       32'(exp_to));
    check({name, "_txn_left"}, 32'(exp_q.size()), 32'd0);
    tick();
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_busy_off"},   32'(busy), 32'd0);
    check({name, "_pass_hold"},  32'(pass), 32'((exp_err == 0) && !exp_to));
    exp_q.delete();
    tie_low    = 1'b0;
    corrupt_en = 1'b0;
    repeat (30) tick();
  endtask

  initial begin
    int          n;
    logic [15:0] rb;
    int          rl;
    rst = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    run_test("t1_basic",   16'h0000, 3, 1'b0, 16'h0, 1'b0, 1'b0);
    run_test("t2_len0",    16'h0123, 0, 1'b0, 16'h0, 1'b0, 1'b0);
    run_test("t3_wrap",    16'h1FFE, 4, 1'b0, 16'h0, 1'b0, 1'b0);
    run_test("t4_corrupt", 16'h0004, 4, 1'b1, 16'h0005, 1'b0, 1'b0);
    run_test("t5_timeout", 16'h0010, 2, 1'b0, 16'h0, 1'b1, 1'b0);
    run_test("t5_after",   16'h0010, 2, 1'b0, 16'h0, 1'b0, 1'b0);
    run_test("t6_midstart", 16'h0040, 3, 1'b1, 16'h0041, 1'b0, 1'b1);

    // Start coinciding with reset is dropped.
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    check("rst_start_busy", 32'(busy), 32'd0);

    // Reset during the first readback wait.
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{rd: 1'b0, addr: 16'(i), data: TB_SEED - 8'(i)});
    exp_q.push_back('{rd: 1'b1, addr: 16'd0, data: 8'h00});
    base_addr = 16'd0; length = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!rd_en && n < 5000) begin tick(); n++; end
    check("rst_mid_rd_seen", 32'(rd_en), 32'd1);
    n = 0;
    while (rd_en && n < 100) begin tick(); n++; end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("rst_mid");
    check("rst_mid_txn_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (40) tick();
    run_test("t6_rerun", 16'h0000, 3, 1'b0, 16'h0, 1'b0, 1'b0);

    // Randomized runs.
    for (int k = 0; k < 6; k++) begin
      rb = 16'($urandom_range(0, 65535));
      rl = int'($urandom_range(1, 5));
      run_test($sformatf("rand%0d", k), rb, rl, 1'($urandom_range(0, 1)),
               (rb + 16'($urandom_range(0, rl - 1))) & 16'h1FFF, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
